// File: rtl/image_frame_store.sv
// Frame store: loads a 2^AW x 2^AW image, serves engine reads/writes, then streams the result out.
// Optional IMG_CHECKSUM_EN adds dp_sum, a running sum of accepted dump beats.
//
// state | meaning
// LOAD  | accepting input pixels into in_mem in raster order
// SERVE | engine owns the buffers; out_we writes out_mem, done bits accumulate
// DUMP  | streaming out_mem through a registered valid/ready stage
module image_frame_store #(
  parameter int AW    = 6,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [PIX_W-1:0] ld_pix,
  input  logic [AW-1:0]    row,
  input  logic [AW-1:0]    col,
  output logic [PIX_W-1:0] in_pix,
  input  logic             out_we,
  input  logic [PIX_W-1:0] out_pix,
  input  logic             mirror_done,
  input  logic             gray_done,
  input  logic             filter_done,
  output logic             proc_busy,
  output logic [2:0]       stat,
  output logic             dp_valid,
  input  logic             dp_ready,
  output logic [PIX_W-1:0] dp_pix,
  output logic             dp_last,
`ifdef IMG_CHECKSUM_EN
  output logic             frame_done,
  output logic [PIX_W-1:0] dp_sum
`else
  output logic             frame_done
`endif
);

  localparam int DEPTH = 1 << (2 * AW);

  typedef enum logic [1:0] {LOAD, SERVE, DUMP} state_t;

  state_t state_q, state_d;

  logic [PIX_W-1:0]  in_mem  [DEPTH];
  logic [PIX_W-1:0]  out_mem [DEPTH];

  logic [2*AW-1:0]   ld_cnt_q;
  logic [2*AW-1:0]   dp_cnt_q;
  logic              dp_valid_q;
  logic              dp_last_q;
  logic [PIX_W-1:0]  dp_pix_q;
  logic              frame_done_q;
  logic [2:0]        stat_q;

  logic              ld_acc;
  logic              dp_acc;
  logic              dp_fetch;
  logic              dp_fin;
  logic              serve_entry;
  logic              dump_entry;

  assign ld_acc = ld_valid && ld_ready;
  assign dp_acc = dp_valid_q && dp_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ld_ready    = 1'b0;
    proc_busy   = 1'b0;
    dp_fetch    = 1'b0;
    dp_fin      = 1'b0;
    serve_entry = 1'b0;
    dump_entry  = 1'b0;
    case (state_q)
      LOAD: begin
        ld_ready = !rst;
        if (ld_valid && !rst && (&ld_cnt_q)) begin
          state_d     = SERVE;
          serve_entry = 1'b1;
        end
      end
      SERVE: begin
        proc_busy = 1'b1;
        if (filter_done) begin
          state_d    = DUMP;
          dump_entry = 1'b1;
        end
      end
      DUMP: begin
        // Refill the output register whenever it is empty or being drained.
        if (dp_acc && dp_last_q) begin
          dp_fin  = 1'b1;
          state_d = LOAD;
        end else if (!dp_valid_q || dp_acc) begin
          dp_fetch = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Image arrays are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_acc)
      in_mem[ld_cnt_q] <= ld_pix;
    if (proc_busy && out_we && !rst)
      out_mem[{row, col}] <= out_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q     <= '0;
      dp_cnt_q     <= '0;
      dp_valid_q   <= 1'b0;
      dp_last_q    <= 1'b0;
      dp_pix_q     <= '0;
      frame_done_q <= 1'b0;
      stat_q       <= '0;
    end else begin
      frame_done_q <= dp_fin;
      if (ld_acc)
        ld_cnt_q <= ld_cnt_q + 1'b1;
      if (serve_entry)
        stat_q <= '0;
      else if (proc_busy)
        stat_q <= stat_q | {filter_done, gray_done, mirror_done};
      if (dump_entry)
        dp_cnt_q <= '0;
      if (dp_fin) begin
        dp_valid_q <= 1'b0;
        dp_last_q  <= 1'b0;
      end else if (dp_fetch) begin
        dp_pix_q   <= out_mem[dp_cnt_q];
        dp_valid_q <= 1'b1;
        dp_last_q  <= &dp_cnt_q;
        dp_cnt_q   <= dp_cnt_q + 1'b1;
      end
    end
  end

`ifdef IMG_CHECKSUM_EN
  logic [PIX_W-1:0] dp_sum_q;

  always_ff @(posedge clk) begin
    if (rst || dump_entry) dp_sum_q <= '0;
    else if (dp_acc)       dp_sum_q <= dp_sum_q + dp_pix_q;
  end

  assign dp_sum = dp_sum_q;
`endif

  assign in_pix     = in_mem[{row, col}];
  assign stat       = stat_q;
  assign dp_valid   = dp_valid_q;
  assign dp_pix     = dp_pix_q;
  assign dp_last    = dp_last_q;
  assign frame_done = frame_done_q;

endmodule
